// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
//
// Shares one uart_tx byte transmitter between two byte producers:
//   source 0 - CPU MMIO store path
//   source 1 - debug/trace path
// Each source owns a one-entry holding register behind a valid/ready
// handshake. A round-robin arbiter picks the next byte, and a sequencer
// drives the transmitter's edge-triggered tx_data_valid / tx_ready protocol.
// uart_tx starts a frame on the falling edge of tx_data_valid. It
// acknowledges by dropping tx_ready and raises it again when the frame ends.
//
// Parameters:
//   PULSE_LEN    cycles tx_data_valid is held high (2..255)
//   ACK_TIMEOUT  cycles to wait for tx_ready to fall after release (4..255)
//
// Ports:
//   clk, rst         clock (rising edge), asynchronous active-high reset
//   s0_valid/s0_data source 0 byte handshake in; s0_ready = holding reg empty
//   s1_valid/s1_data source 1 byte handshake in; s1_ready = holding reg empty
//   tx_data          registered byte to the transmitter
//   tx_data_valid    registered start strobe to the transmitter
//   tx_ready         transmitter idle flag
//   busy             sequencer not in IDLE (registered)
//   last_src         source index of the most recent grant
//   err_timeout      sticky: transmitter never acknowledged a byte
//   err_clr          clears err_timeout (a simultaneous timeout wins)
// ---------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter int unsigned PULSE_LEN   = 4,
    parameter int unsigned ACK_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       s0_valid,
    input  logic [7:0] s0_data,
    output logic       s0_ready,
    input  logic       s1_valid,
    input  logic [7:0] s1_data,
    output logic       s1_ready,
    output logic [7:0] tx_data,
    output logic       tx_data_valid,
    input  logic       tx_ready,
    output logic       busy,
    output logic       last_src,
    output logic       err_timeout,
    input  logic       err_clr
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HIGH,
        ST_ACK,
        ST_DRAIN
    } state_t;

    localparam logic [7:0] L_PULSE_LAST = 8'(PULSE_LEN - 1);
    localparam logic [7:0] L_ACK_LAST   = 8'(ACK_TIMEOUT - 1);

    state_t     r_state;
    state_t     w_state_next;
    logic [7:0] r_cnt;
    logic [7:0] w_cnt_next;
    logic [7:0] r_tx_data;
    logic [7:0] w_tx_data_next;
    logic       r_tx_valid;
    logic       w_tx_valid_next;
    logic       r_last_src;
    logic       w_last_src_next;
    logic       r_busy;
    logic       r_err;

    // Holding registers: r_sN_ready is the "empty" flag, stored directly.
    logic       r_s0_ready;
    logic       r_s1_ready;
    logic [7:0] r_data0;
    logic [7:0] r_data1;

    logic       w_full0;
    logic       w_full1;
    logic       w_grant;
    logic       w_grant_src;
    logic       w_timeout;

    assign w_full0 = ~r_s0_ready;
    assign w_full1 = ~r_s1_ready;

    // Round-robin: a lone full register wins outright; on a tie the source
    // that did not win last time goes next.
    assign w_grant_src = (w_full0 && w_full1) ? ~r_last_src : w_full1;

    // -----------------------------------------------------------------------
    // Next-state / next-output logic
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // can leave one unassigned and infer a latch.
        w_state_next    = r_state;
        w_cnt_next      = r_cnt;
        w_tx_data_next  = r_tx_data;
        w_tx_valid_next = 1'b0;
        w_last_src_next = r_last_src;
        w_grant         = 1'b0;
        w_timeout       = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (tx_ready && (w_full0 || w_full1)) begin
                    w_grant         = 1'b1;
                    w_tx_data_next  = w_grant_src ? r_data1 : r_data0;
                    w_last_src_next = w_grant_src;
                    w_cnt_next      = 8'd0;
                    w_tx_valid_next = 1'b1;
                    w_state_next    = ST_HIGH;
                end
            end
            ST_HIGH: begin
                if (r_cnt == L_PULSE_LAST) begin
                    w_cnt_next   = 8'd0;
                    w_state_next = ST_ACK;
                end else begin
                    w_cnt_next      = r_cnt + 8'd1;
                    w_tx_valid_next = 1'b1;
                end
            end
            ST_ACK: begin
                if (!tx_ready) begin
                    w_state_next = ST_DRAIN;
                end else if (r_cnt == L_ACK_LAST) begin
                    // The byte is dropped; it is not retried.
                    w_timeout    = 1'b1;
                    w_state_next = ST_IDLE;
                end else begin
                    w_cnt_next = r_cnt + 8'd1;
                end
            end
            ST_DRAIN: begin
                // Frame in progress: no timeout, wait for the transmitter.
                if (tx_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Sequencer state and registered outputs
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values, independent of statement order.
        if (rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= 8'd0;
            r_tx_data  <= 8'd0;
            r_tx_valid <= 1'b0;
            r_last_src <= 1'b1;
            r_busy     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_cnt      <= w_cnt_next;
            r_tx_data  <= w_tx_data_next;
            r_tx_valid <= w_tx_valid_next;
            r_last_src <= w_last_src_next;
            r_busy     <= (w_state_next != ST_IDLE);
            // A timeout in the same cycle as err_clr leaves the flag set.
            if (w_timeout) begin
                r_err <= 1'b1;
            end else if (err_clr) begin
                r_err <= 1'b0;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Holding-register flags. Load needs the register empty and grant needs
    // it full, so the two never coincide on the same register.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s0_ready <= 1'b1;
            r_s1_ready <= 1'b1;
        end else begin
            if (s0_valid && r_s0_ready) begin
                r_s0_ready <= 1'b0;
            end else if (w_grant && !w_grant_src) begin
                r_s0_ready <= 1'b1;
            end
            if (s1_valid && r_s1_ready) begin
                r_s1_ready <= 1'b0;
            end else if (w_grant && w_grant_src) begin
                r_s1_ready <= 1'b1;
            end
        end
    end

    // NOTE: the data bytes carry no reset; they are only read while the
    // matching full flag is set, and that flag is cleared by reset.
    always_ff @(posedge clk) begin
        if (s0_valid && r_s0_ready) begin
            r_data0 <= s0_data;
        end
        if (s1_valid && r_s1_ready) begin
            r_data1 <= s1_data;
        end
    end

    assign s0_ready      = r_s0_ready;
    assign s1_ready      = r_s1_ready;
    assign tx_data       = r_tx_data;
    assign tx_data_valid = r_tx_valid;
    assign busy          = r_busy;
    assign last_src      = r_last_src;
    assign err_timeout   = r_err;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_arbiter
//
// Self-checking bench for uart_tx_arbiter. A small uart_tx model sits on
// tx_data / tx_data_valid / tx_ready. It synchronises tx_data_valid through
// two flops and starts on its falling edge. It drops tx_ready, shifts a
// 10-bit frame (4 cycles per bit) and decodes the line back into bytes.
// ---------------------------------------------------------------------------
module tb_uart_tx_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       s0_valid;
    logic [7:0] s0_data;
    logic       s0_ready;
    logic       s1_valid;
    logic [7:0] s1_data;
    logic       s1_ready;
    logic [7:0] tx_data;
    logic       tx_data_valid;
    logic       tx_ready;
    logic       busy;
    logic       last_src;
    logic       err_timeout;
    logic       err_clr;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.PULSE_LEN(4), .ACK_TIMEOUT(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .s0_valid      (s0_valid),
        .s0_data       (s0_data),
        .s0_ready      (s0_ready),
        .s1_valid      (s1_valid),
        .s1_data       (s1_data),
        .s1_ready      (s1_ready),
        .tx_data       (tx_data),
        .tx_data_valid (tx_data_valid),
        .tx_ready      (tx_ready),
        .busy          (busy),
        .last_src      (last_src),
        .err_timeout   (err_timeout),
        .err_clr       (err_clr)
    );

    // -----------------------------------------------------------------------
    // uart_tx model
    // -----------------------------------------------------------------------
    logic       m_en;
    logic       tb_ready;
    logic       m_ready;
    logic       m_active;
    logic [2:0] m_sync;
    logic [9:0] m_shift;
    logic [9:0] m_rx;
    logic [3:0] m_bit;
    logic [1:0] m_baud;
    logic       m_txd;
    int         m_ferr = 0;
    logic [7:0] rx_q[$];

    assign tx_ready = m_en ? m_ready : tb_ready;
    assign m_txd    = m_active ? m_shift[0] : 1'b1;

    always @(posedge clk) begin
        if (rst) begin
            m_sync   <= 3'b000;
            m_active <= 1'b0;
            m_ready  <= 1'b1;
            m_shift  <= 10'h3FF;
            m_rx     <= 10'h000;
            m_bit    <= 4'd0;
            m_baud   <= 2'd0;
        end else begin
            m_sync <= {m_sync[1:0], tx_data_valid};
            if (!m_active) begin
                if (m_en && m_sync[2] && !m_sync[1]) begin
                    m_active <= 1'b1;
                    m_ready  <= 1'b0;
                    m_shift  <= {1'b1, tx_data, 1'b0};
                    m_bit    <= 4'd0;
                    m_baud   <= 2'd0;
                end
            end else begin
                m_baud <= m_baud + 2'd1;
                if (m_baud == 2'd3) begin
                    m_shift <= {1'b1, m_shift[9:1]};
                    m_rx    <= {m_txd, m_rx[9:1]};
                    m_bit   <= m_bit + 4'd1;
                    if (m_bit == 4'd9) begin
                        // Frame = {m_txd, m_rx[9:1]}: start at m_rx[1], stop is m_txd.
                        m_active <= 1'b0;
                        m_ready  <= 1'b1;
                        rx_q.push_back(m_rx[9:2]);
                        if (m_rx[1] !== 1'b0 || m_txd !== 1'b1) begin
                            m_ferr <= m_ferr + 1;
                        end
                    end
                end
            end
        end
    end

    // Pulse monitor: counts rising edges and records the last high length.
    int   pulse_cnt  = 0;
    int   mon_run    = 0;
    int   last_pulse = 0;
    logic mon_prev   = 1'b0;

    always @(negedge clk) begin
        if (tx_data_valid) begin
            if (!mon_prev) pulse_cnt++;
            mon_run++;
        end else if (mon_run != 0) begin
            last_pulse = mon_run;
            mon_run    = 0;
        end
        mon_prev = tx_data_valid;
    end

    // -----------------------------------------------------------------------
    // Helpers
    // -----------------------------------------------------------------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        s0_valid = 1'b0;
        s1_valid = 1'b0;
        s0_data  = 8'h00;
        s1_data  = 8'h00;
        err_clr  = 1'b0;
        tick(2);
        rst = 1'b0;
        rx_q.delete();
        tick(1);
    endtask

    // Hold valid until the byte is taken; returns on the negedge after the
    // accepting clock edge.
    task automatic send(input bit src, input logic [7:0] d);
        bit ok = 1'b0;
        if (src) begin s1_valid = 1'b1; s1_data = d; end
        else     begin s0_valid = 1'b1; s0_data = d; end
        for (int i = 0; i < 2000; i++) begin
            ok = src ? s1_ready : s0_ready;
            @(negedge clk);
            if (ok) break;
        end
        if (src) s1_valid = 1'b0;
        else     s0_valid = 1'b0;
        check(src ? "s1_accept" : "s0_accept", {31'd0, ok}, 32'd1);
    endtask

    task automatic wait_idle(input int n_exp);
        int i;
        for (i = 0; i < 3000; i++) begin
            if (rx_q.size() >= n_exp && !busy && s0_ready && s1_ready) break;
            @(negedge clk);
        end
        check("drain_done", {31'd0, (i < 3000)}, 32'd1);
    endtask

    task automatic wait_valid(input logic lvl);
        int i;
        for (i = 0; i < 200; i++) begin
            if (tx_data_valid === lvl) break;
            @(negedge clk);
        end
        check("valid_seen", {31'd0, (i < 200)}, 32'd1);
    endtask

    function automatic logic [7:0] rx_at(input int i);
        return (i < rx_q.size()) ? rx_q[i] : 8'hxx;
    endfunction

    // -----------------------------------------------------------------------
    // Table of arbitration vectors, applied from reset in sequence
    // -----------------------------------------------------------------------
    typedef struct {
        logic       v0;
        logic [7:0] d0;
        logic       v1;
        logic [7:0] d1;
        int         n_exp;
        logic [7:0] e0;
        logic [7:0] e1;
        logic       exp_last;
    } vec_t;

    vec_t       vecs[5];
    logic [7:0] bp_exp[9];

    initial begin
        int n;
        int pcnt;

        vecs[0] = '{1'b1, 8'h11, 1'b1, 8'h22, 2, 8'h11, 8'h22, 1'b1}; // tie, last=1 -> s0 first
        vecs[1] = '{1'b1, 8'hA5, 1'b0, 8'h00, 1, 8'hA5, 8'h00, 1'b0}; // s0 alone
        vecs[2] = '{1'b1, 8'h66, 1'b1, 8'h77, 2, 8'h77, 8'h66, 1'b0}; // tie, last=0 -> s1 first
        vecs[3] = '{1'b0, 8'h00, 1'b1, 8'h3C, 1, 8'h3C, 8'h00, 1'b1}; // s1 alone
        vecs[4] = '{1'b1, 8'h01, 1'b1, 8'h02, 2, 8'h01, 8'h02, 1'b1}; // tie, last=1 -> s0 first
        bp_exp  = '{8'h00, 8'h80, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};

        rst      = 1'b1;
        m_en     = 1'b1;
        tb_ready = 1'b1;
        s0_valid = 1'b0;
        s1_valid = 1'b0;
        s0_data  = 8'h00;
        s1_data  = 8'h00;
        err_clr  = 1'b0;

        // ---- Single byte -------------------------------------------------
        do_reset();
        check("rst_tx_data",  {24'd0, tx_data},       32'h00);
        check("rst_valid",    {31'd0, tx_data_valid}, 32'd0);
        check("rst_busy",     {31'd0, busy},          32'd0);
        check("rst_last_src", {31'd0, last_src},      32'd1);
        check("rst_err",      {31'd0, err_timeout},   32'd0);
        check("rst_s0_ready", {31'd0, s0_ready},      32'd1);
        check("rst_s1_ready", {31'd0, s1_ready},      32'd1);

        send(1'b0, 8'hA5);
        check("sb_s0_full",   {31'd0, s0_ready},      32'd0);
        tick(1);   // grant edge has passed
        check("sb_tx_data",   {24'd0, tx_data},       32'hA5);
        check("sb_valid_hi",  {31'd0, tx_data_valid}, 32'd1);
        check("sb_s0_ready",  {31'd0, s0_ready},      32'd1);
        check("sb_busy",      {31'd0, busy},          32'd1);
        check("sb_last_src",  {31'd0, last_src},      32'd0);
        for (n = 0; n < 200 && busy; n++) tick(1);
        check("sb_busy_fell",     {31'd0, busy},     32'd0);
        check("sb_ready_at_idle", {31'd0, tx_ready}, 32'd1);
        check("sb_pulse_len",     last_pulse,        32'd4);
        check("sb_rx_count",      rx_q.size(),       32'd1);
        check("sb_rx_byte",       {24'd0, rx_at(0)}, 32'hA5);

        // ---- Table-driven arbitration ------------------------------------
        do_reset();
        for (int k = 0; k < 5; k++) begin
            fork
                begin if (vecs[k].v0) send(1'b0, vecs[k].d0); end
                begin if (vecs[k].v1) send(1'b1, vecs[k].d1); end
            join
            wait_idle(vecs[k].n_exp);
            check($sformatf("vec%0d_count", k), rx_q.size(), vecs[k].n_exp);
            check($sformatf("vec%0d_first", k), {24'd0, rx_at(0)}, {24'd0, vecs[k].e0});
            if (vecs[k].n_exp > 1)
                check($sformatf("vec%0d_second", k), {24'd0, rx_at(1)}, {24'd0, vecs[k].e1});
            check($sformatf("vec%0d_last_src", k), {31'd0, last_src}, {31'd0, vecs[k].exp_last});
            rx_q.delete();
        end

        // ---- Contention with a second pair loaded in flight -------------
        do_reset();
        fork
            begin send(1'b0, 8'h11); send(1'b0, 8'h33); end
            begin send(1'b1, 8'h22); send(1'b1, 8'h44); end
        join
        wait_idle(4);
        check("rr_count", rx_q.size(), 32'd4);
        check("rr_b0", {24'd0, rx_at(0)}, 32'h11);
        check("rr_b1", {24'd0, rx_at(1)}, 32'h22);
        check("rr_b2", {24'd0, rx_at(2)}, 32'h33);
        check("rr_b3", {24'd0, rx_at(3)}, 32'h44);

        // ---- Back-pressure: s1 streams 0..7, s0 waits its turn ----------
        do_reset();
        fork
            begin
                for (int b = 0; b < 8; b++) send(1'b1, 8'(b));
            end
            begin
                tick(6);
                send(1'b0, 8'h80);
                tick(20);
                check("bp_s0_held", {31'd0, s0_ready}, 32'd0);
            end
        join
        wait_idle(9);
        check("bp_count", rx_q.size(), 32'd9);
        for (int b = 0; b < 9; b++)
            check($sformatf("bp_b%0d", b), {24'd0, rx_at(b)}, {24'd0, bp_exp[b]});

        // ---- Timeout ------------------------------------------------------
        do_reset();
        m_en     = 1'b0;
        tb_ready = 1'b1;
        send(1'b0, 8'h5A);
        wait_valid(1'b1);
        wait_valid(1'b0);
        n = 0;
        while (!err_timeout && n < 100) begin
            tick(1);
            n++;
        end
        check("to_delay",    n,                     32'd16);
        check("to_err",      {31'd0, err_timeout},  32'd1);
        check("to_idle",     {31'd0, busy},         32'd0);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        check("to_cleared",  {31'd0, err_timeout},  32'd0);

        send(1'b0, 8'h5A);
        wait_valid(1'b1);
        wait_valid(1'b0);
        tick(15);
        check("to2_pre",     {31'd0, err_timeout},  32'd0);
        err_clr = 1'b1;   // coincides with the second timeout edge
        tick(1);
        err_clr = 1'b0;
        check("to2_set_wins", {31'd0, err_timeout}, 32'd1);

        // ---- Reset mid-frame ---------------------------------------------
        do_reset();
        m_en = 1'b1;
        check("rm_err_cleared", {31'd0, err_timeout}, 32'd0);
        fork
            send(1'b0, 8'hC3);
            send(1'b1, 8'h3C);
        join
        wait_valid(1'b1);
        check("rm_s1_full", {31'd0, s1_ready}, 32'd0);
        #2 rst = 1'b1;
        #1;
        check("rm_valid",    {31'd0, tx_data_valid}, 32'd0);
        check("rm_s0_ready", {31'd0, s0_ready},      32'd1);
        check("rm_s1_ready", {31'd0, s1_ready},      32'd1);
        check("rm_busy",     {31'd0, busy},          32'd0);
        check("rm_last_src", {31'd0, last_src},      32'd1);
        check("rm_tx_data",  {24'd0, tx_data},       32'h00);
        @(negedge clk);
        rst = 1'b0;
        rx_q.delete();
        pcnt = pulse_cnt;
        tick(100);
        check("rm_no_pulse", pulse_cnt,   pcnt);
        check("rm_no_rx",    rx_q.size(), 32'd0);

        // ---- Transmitter not ready ---------------------------------------
        do_reset();
        m_en     = 1'b0;
        tb_ready = 1'b0;
        send(1'b0, 8'h96);
        pcnt = pulse_cnt;
        tick(20);
        check("nr_no_pulse", pulse_cnt,               pcnt);
        check("nr_busy",     {31'd0, busy},           32'd0);
        check("nr_s0_full",  {31'd0, s0_ready},       32'd0);
        tb_ready = 1'b1;
        tick(1);
        check("nr_valid",    {31'd0, tx_data_valid},  32'd1);
        check("nr_tx_data",  {24'd0, tx_data},        32'h96);
        check("nr_busy_on",  {31'd0, busy},           32'd1);
        check("nr_s0_ready", {31'd0, s0_ready},       32'd1);

        check("frame_errors", m_ferr, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares one uart_tx byte transmitter between two independent byte producers: source 0 is the CPU MMIO store path and source 1 is the debug/trace path. Each source gets a one-entry holding register behind a valid/ready handshake. A round-robin arbiter picks the next byte, and a sequencer drives the transmitter's edge-triggered tx_data_valid / tx_ready protocol. The block sits between the bus/debug logic and uart_tx, in the same clock domain.

Parameters:
PULSE_LEN, 4, cycles tx_data_valid is held high before release; legal range 2..255.
ACK_TIMEOUT, 16, max cycles after release to wait for tx_ready to fall; legal range 4..255.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-high reset.
s0_valid  in  1  source 0 byte valid.
s0_data  in  8  source 0 byte.
s0_ready  out  1  source 0 holding register empty.
s1_valid  in  1  source 1 byte valid.
s1_data  in  8  source 1 byte.
s1_ready  out  1  source 1 holding register empty.
tx_data  out  8  byte to transmitter; registered.
tx_data_valid  out  1  start strobe to transmitter; registered.
tx_ready  in  1  transmitter idle flag.
busy  out  1  sequencer not in IDLE.
last_src  out  1  source of most recent grant.
err_timeout  out  1  sticky: transmitter failed to accept a byte.
err_clr  in  1  clears err_timeout.

Behaviour:
- Reset (async, rst=1), taking effect immediately:
  - tx_data=0, tx_data_valid=0, busy=0, last_src=1 (so source 0 wins the first tie), err_timeout=0.
  - Both holding registers are emptied, so s0_ready=s1_ready=1. Pending bytes are discarded.
  - The state machine goes to IDLE. Reset mid-frame drops tx_data_valid within the same cycle.
- Transmitter protocol (fixed):
  - uart_tx starts a frame on the falling edge of tx_data_valid, seen after its 2-flop synchroniser.
  - It samples tx_data up to 3 cycles after that edge.
  - It acknowledges by dropping tx_ready, which it raises again when the frame ends.
  - tx_data must remain stable from grant until tx_ready is observed low.
- Holding registers:
  - sN_ready = ~fullN, driven directly from a flop.
  - On sN_valid & sN_ready, dataN is captured and fullN is set on that edge.
  - A grant clears fullN on the grant edge, so sN_ready rises in the next cycle.
  - Load and grant of the same register cannot coincide, because grant requires full=1 and load requires full=0.
- State machine (IDLE, HIGH, ACK, DRAIN):
  - IDLE:
    - tx_data_valid=0.
    - If tx_ready=1 and at least one holding register is full, grant and go to HIGH.
    - Grant: if only one register is full, grant it. If both are full, grant source ~last_src.
    - On grant: tx_data <= granted byte, last_src <= granted index, cnt <= 0.
  - HIGH:
    - tx_data_valid=1 and cnt increments each cycle.
    - When cnt==PULSE_LEN-1: tx_data_valid <= 0, cnt <= 0, go to ACK.
    - tx_data_valid is therefore high for exactly PULSE_LEN cycles.
  - ACK:
    - tx_data_valid=0.
    - If tx_ready==0, go to DRAIN.
    - Otherwise, if cnt==ACK_TIMEOUT-1: set err_timeout and go to IDLE. The byte is lost and is not retried.
    - Otherwise cnt increments.
  - DRAIN: wait for tx_ready==1, then go to IDLE. There is no timeout in this state.
- busy = (state != IDLE), registered.
- Fairness:
  - The minimum byte-to-byte spacing is one IDLE cycle. This guarantees tx_data_valid is low for at least one cycle before the next high.
  - Under continuous load from both sources, grants alternate 0,1,0,1.
- err_timeout:
  - Set by a timeout and cleared by err_clr.
  - If set and clear occur in the same cycle, set wins.
- Counter: 8 bits, never wraps within legal parameter ranges.
- Ready/valid inputs held while sN_ready=0 are ignored; no data is dropped.

Test Plan:
- Single byte: after reset, s0 sends 0xA5 and a uart_tx model is attached.
  - tx_data=0xA5 from the cycle after grant.
  - tx_data_valid is high for exactly 4 cycles.
  - The tx line shows start bit, 0xA5 LSB first, then stop bit.
  - s0_ready returns to 1 one cycle after grant; busy falls after tx_ready rises.
- Contention: both sources load in the same cycle (0x11 on s0, 0x22 on s1).
  - Bytes go out in the order 0x11 then 0x22, since last_src=1 after reset.
  - Repeat with s0=0x33 and s1=0x44 loaded while the first pair is in flight: the order is 0x33 then 0x44, because round-robin alternates.
- Back-pressure: s1 streams 0x00..0x07 with valid held high.
  - s1_ready toggles correctly and every byte is transmitted exactly once, in order.
  - Meanwhile the s0 holding register stays full without loss until its turn.
- Timeout: hold tx_ready=1 permanently and send 0x5A.
  - err_timeout rises exactly 16 cycles after tx_data_valid falls.
  - The state returns to IDLE.
  - err_clr=1 clears it; err_clr asserted in the same cycle as a second timeout leaves it set.
- Reset mid-frame: assert rst during HIGH with s1 full.
  - tx_data_valid=0 and s0_ready=s1_ready=1 immediately.
  - After reset is released, no byte is transmitted without a new request.
- Transmitter not ready: hold tx_ready=0 while s0 is full.
  - No grant occurs and tx_data_valid stays 0.
  - Raising tx_ready leads to a grant in the first IDLE cycle that sees tx_ready=1.
